// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one outstanding
// imem request at a time and buffers {pc, instr} pairs for decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       flush_i,
    input  logic [31:0]                flush_pc_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_data_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fpc;
    logic [31:0]   r_daddr;
    logic [31:0]   r_pc_mem  [DEPTH];
    logic [31:0]   r_ins_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_pop_cnt;
    logic          w_room;

    assign w_pop     = (r_cnt != '0) && instr_ready_i;
    assign w_push    = (r_state == S_REQ) && imem_ack_i && !flush_i;
    assign w_pop_cnt = r_cnt - CW'(w_pop) + CW'(w_push);
    assign w_room    = w_pop_cnt < CW'(DEPTH);

    // Abandoned request keeps its address on the bus until memory acks it.
    assign imem_req_o    = (r_state == S_REQ) || (r_state == S_DROP);
    assign imem_addr_o   = (r_state == S_DROP) ? r_daddr : r_fpc;
    assign instr_valid_o = (r_cnt != '0);
    assign instr_o       = instr_valid_o ? r_ins_mem[r_rd] : 32'h0;
    assign pc_o          = instr_valid_o ? r_pc_mem[r_rd] : 32'h0;
    assign count_o       = r_cnt;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr]  <= r_fpc;
            r_ins_mem[r_wr] <= imem_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_fpc   <= RESET_PC;
            r_daddr <= RESET_PC;
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
        end else if (flush_i) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_fpc <= flush_pc_i;
            unique case (r_state)
                S_REQ: begin
                    if (imem_ack_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DROP;
                        r_daddr <= r_fpc;
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end else begin
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_push) r_wr <= r_wr + AW'(1);
            r_cnt <= w_pop_cnt;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i && w_room) r_state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ack_i) begin
                        r_fpc   <= r_fpc + 32'd4;
                        r_state <= (start_i && w_room) ? S_REQ : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [31:0]   flush_pc_i = 32'h0;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_ack_i = 1'b0;
    logic [31:0]   imem_data_i = 32'h0;
    logic          instr_valid_o;
    logic [31:0]   instr_o;
    logic [31:0]   pc_o;
    logic          instr_ready_i = 1'b0;
    logic [CW-1:0] count_o;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .instr_ready_i(instr_ready_i),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memw(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5AC3C3;
    endfunction

    // Reference model: a queue of {pc, instr} plus "request outstanding"
    // and "outstanding request is being thrown away" flags.
    bit [63:0]   m_q[$];
    logic [31:0] m_fpc   = 32'h0;
    logic [31:0] m_daddr = 32'h0;
    bit          m_pend  = 1'b0;
    bit          m_drop  = 1'b0;

    function automatic logic [31:0] exp_addr();
        return m_drop ? m_daddr : m_fpc;
    endfunction

    function automatic void model_step();
        bit pop;
        pop = (m_q.size() != 0) && instr_ready_i;
        if (flush_i) begin
            m_q.delete();
            if (m_pend && !m_drop && !imem_ack_i) begin
                m_drop  = 1'b1;
                m_daddr = m_fpc;
            end else if (m_pend && imem_ack_i) begin
                m_pend = 1'b0;
                m_drop = 1'b0;
            end
            m_fpc = flush_pc_i;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_drop) begin
                if (imem_ack_i) begin
                    m_pend = 1'b0;
                    m_drop = 1'b0;
                end
            end else if (m_pend) begin
                if (imem_ack_i) begin
                    m_q.push_back({m_fpc, imem_data_i});
                    m_fpc  = m_fpc + 32'd4;
                    m_pend = start_i && (m_q.size() < DEPTH);
                end
            end else begin
                m_pend = start_i && (m_q.size() < DEPTH);
            end
        end
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_q.delete();
            m_fpc   = 32'h0;
            m_daddr = 32'h0;
            m_pend  = 1'b0;
            m_drop  = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk_i) begin
        chk("model_req", 32'(imem_req_o), 32'(m_pend));
        chk("model_addr", imem_addr_o, exp_addr());
        chk("model_valid", 32'(instr_valid_o), 32'(m_q.size() != 0));
        chk("model_count", 32'(count_o), 32'(m_q.size()));
        chk("model_pc", pc_o, (m_q.size() != 0) ? m_q[0][63:32] : 32'h0);
        chk("model_instr", instr_o, (m_q.size() != 0) ? m_q[0][31:0] : 32'h0);
    end

    // Memory: acks once the request has waited wlim cycles.
    int wcnt   = 0;
    int wlim   = 0;
    bit rand_w = 1'b0;

    task automatic tick();
        bit pend_b;
        pend_b      = m_pend;
        imem_ack_i  = pend_b && (wcnt >= wlim);
        imem_data_i = memw(exp_addr());
        @(posedge clk_i);
        if (imem_ack_i) begin
            wcnt = 0;
            if (rand_w) wlim = $urandom_range(0, 3);
        end else if (pend_b) begin
            wcnt++;
        end
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        #1;
        rst_i         = 1'b0;
        start_i       = 1'b0;
        flush_i       = 1'b0;
        instr_ready_i = 1'b0;
        imem_ack_i    = 1'b0;
        wcnt          = 0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    int nreq;

    initial begin
        #2;
        chk("rst_req", 32'(imem_req_o), 32'h0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_count", 32'(count_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // stream at zero wait states
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        wlim = 0;
        tick();
        chk("stream_req", 32'(imem_req_o), 32'h1);
        chk("stream_addr0", imem_addr_o, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_pc", pc_o, 32'(4 * i));
            chk("stream_instr", instr_o, memw(32'(4 * i)));
        end

        // backpressure
        apply_reset();
        start_i = 1'b1;
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (imem_ack_i) nreq++;
        end
        chk("bp_nreq", 32'(nreq), 32'd4);
        chk("bp_count", 32'(count_o), 32'd4);
        chk("bp_req", 32'(imem_req_o), 32'h0);
        chk("bp_head", pc_o, 32'h0);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        chk("bp_pop_count", 32'(count_o), 32'd3);
        chk("bp_pop_head", pc_o, 32'h4);
        chk("bp_req16", 32'(imem_req_o), 32'h1);
        chk("bp_addr16", imem_addr_o, 32'h10);
        tick();
        chk("bp_refill", 32'(count_o), 32'd4);

        // three wait states
        apply_reset();
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        wlim = 3;
        repeat (12) tick();
        chk("ws_valid12", 32'(instr_valid_o), 32'h0);
        chk("ws_addr12", imem_addr_o, 32'h8);
        tick();
        chk("ws_pc13", pc_o, 32'h8);
        chk("ws_addr13", imem_addr_o, 32'hC);

        // flush while a request is pending
        apply_reset();
        start_i = 1'b1;
        instr_ready_i = 1'b0;
        wlim = 3;
        repeat (10) tick();
        chk("fp_addr", imem_addr_o, 32'h8);
        chk("fp_count", 32'(count_o), 32'd2);
        flush_i = 1'b1;
        flush_pc_i = 32'h100;
        tick();
        flush_i = 1'b0;
        chk("fp_count0", 32'(count_o), 32'h0);
        chk("fp_hold_req", 32'(imem_req_o), 32'h1);
        chk("fp_hold_addr", imem_addr_o, 32'h8);
        tick();
        tick();
        chk("fp_idle", 32'(imem_req_o), 32'h0);
        chk("fp_nopush", 32'(count_o), 32'h0);
        tick();
        chk("fp_newaddr", imem_addr_o, 32'h100);

        // flush coinciding with ack and pop, then flush inside the drop
        apply_reset();
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        wlim = 0;
        repeat (4) tick();
        flush_i = 1'b1;
        flush_pc_i = 32'h100;
        tick();
        flush_i = 1'b0;
        chk("fa_count", 32'(count_o), 32'h0);
        chk("fa_req", 32'(imem_req_o), 32'h0);
        tick();
        chk("fa_addr", imem_addr_o, 32'h100);
        wlim = 2;
        flush_i = 1'b1;
        flush_pc_i = 32'h180;
        tick();
        flush_pc_i = 32'h200;
        tick();
        flush_i = 1'b0;
        chk("fd_hold", imem_addr_o, 32'h100);
        tick();
        chk("fd_idle", 32'(imem_req_o), 32'h0);
        tick();
        chk("fd_addr", imem_addr_o, 32'h200);

        // wrap-around and stop mid-request
        apply_reset();
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        wlim = 0;
        flush_i = 1'b1;
        flush_pc_i = 32'hFFFF_FFF8;
        tick();
        flush_i = 1'b0;
        repeat (3) tick();
        chk("wrap_addr", imem_addr_o, 32'h0);
        chk("wrap_head", pc_o, 32'hFFFF_FFFC);
        start_i = 1'b0;
        wlim = 2;
        repeat (3) tick();
        chk("stop_req", 32'(imem_req_o), 32'h0);
        chk("stop_pc", pc_o, 32'h0);
        chk("stop_instr", instr_o, memw(32'h0));
        tick();
        chk("stop_empty", 32'(instr_valid_o), 32'h0);

        // randomized traffic with occasional asynchronous reset
        apply_reset();
        rand_w = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) begin
                #2;
                rst_i = 1'b0;
                imem_ack_i = 1'b0;
                wcnt = 0;
                #1;
                chk("arst_req", 32'(imem_req_o), 32'h0);
                chk("arst_count", 32'(count_o), 32'h0);
                @(negedge clk_i);
                rst_i = 1'b1;
            end else begin
                start_i       = ($urandom_range(0, 7) != 0);
                instr_ready_i = ($urandom_range(0, 2) != 0);
                flush_i       = ($urandom_range(0, 15) == 0);
                flush_pc_i    = $urandom();
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
